// File: rtl/fan_pwm_driver_pkg.sv
// ============================================================================
// Module   : fan_pwm_driver_pkg
// Purpose  : Fan mode encodings and FSM states shared by the fan control blocks
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fan_pwm_driver_pkg;

  localparam logic [3:0] MODE_OFF = 4'b0001;
  localparam logic [3:0] MODE_L1  = 4'b0010;
  localparam logic [3:0] MODE_L2  = 4'b0100;
  localparam logic [3:0] MODE_L3  = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RAMP_DOWN = 2'd2
  } fan_state_e;

  function automatic logic mode_is_onehot(input logic [3:0] m);
    return $onehot(m);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fan_pwm_driver_if.sv
// ============================================================================
// Module   : fan_pwm_driver_if
// Purpose  : Mode input and PWM/status outputs of the fan PWM driver
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fan_pwm_driver_if #(
  parameter int PWM_STEPS = 100
) ();

  localparam int DW = $clog2(PWM_STEPS + 1);

  logic [3:0]    mode;
  logic          pwm_out;
  logic [DW-1:0] duty_cur;
  logic          period_start;
  logic          busy;
  logic          mode_err;

  modport master (
    output mode,
    input  pwm_out, duty_cur, period_start, busy, mode_err
  );

  modport slave (
    input  mode,
    output pwm_out, duty_cur, period_start, busy, mode_err
  );

endinterface

`default_nettype wire

// File: rtl/fan_pwm_driver_tick_gen.sv
// ============================================================================
// Module   : fan_pwm_driver_tick_gen
// Purpose  : Prescaler and PWM period counter; flags the last tick of a period
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fan_pwm_driver_tick_gen #(
  parameter int PRESC_DIV = 100,
  parameter int PWM_STEPS = 100,
  parameter int CW        = 7
) (
  input  wire           clk,
  input  wire           reset_p,
  output logic          boundary_o,
  output logic [CW-1:0] pwm_cnt_o
);

  localparam int            c_PW        = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(PRESC_DIV - 1);
  localparam logic [CW-1:0]   c_CNT_MAX   = CW'(PWM_STEPS - 1);

  logic [c_PW-1:0] presc_q, presc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            w_tick;

  always_comb begin
    w_tick     = (presc_q == c_PRESC_MAX);
    boundary_o = w_tick && (cnt_q == c_CNT_MAX);
    presc_d    = w_tick ? '0 : presc_q + 1'b1;
    cnt_d      = cnt_q;
    if (w_tick) begin
      cnt_d = boundary_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pwm_cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/fan_pwm_driver.sv
// ============================================================================
// Module   : fan_pwm_driver
// Purpose  : One-hot fan mode to glitch-free PWM; FAN_RAMP_EN adds a soft ramp
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fan_pwm_driver
  import fan_pwm_driver_pkg::*;
#(
  parameter int PRESC_DIV    = 100,
  parameter int PWM_STEPS    = 100,
  parameter int DUTY_L1      = 30,
  parameter int DUTY_L2      = 60,
  parameter int DUTY_L3      = 100,
  parameter int RAMP_PERIODS = 4
) (
  input wire               clk,
  input wire               reset_p,
  fan_pwm_driver_if.slave  bus
);

  localparam int c_DW = $clog2(PWM_STEPS + 1);

  if (PRESC_DIV < 1 || RAMP_PERIODS < 1 || DUTY_L3 > PWM_STEPS) begin : g_param_check
    $error("fan_pwm_driver: illegal parameter combination");
  end

  logic            w_boundary;
  logic [c_DW-1:0] w_pwm_cnt;
  logic [c_DW-1:0] w_target;
  logic            w_mode_valid;

  logic [c_DW-1:0] duty_cur_q, duty_cur_d;
  logic            pwm_out_q;
  logic            period_start_q;
  logic            busy_q;
  logic            mode_err_q;

  fan_pwm_driver_tick_gen #(
    .PRESC_DIV (PRESC_DIV),
    .PWM_STEPS (PWM_STEPS),
    .CW        (c_DW)
  ) u_tick_gen (
    .clk        (clk),
    .reset_p    (reset_p),
    .boundary_o (w_boundary),
    .pwm_cnt_o  (w_pwm_cnt)
  );

  // Any non-one-hot mode parks the fan (target 0) and raises mode_err.
  always_comb begin
    w_target     = '0;
    w_mode_valid = mode_is_onehot(bus.mode);
    case (bus.mode)
      MODE_L1: w_target = c_DW'(DUTY_L1);
      MODE_L2: w_target = c_DW'(DUTY_L2);
      MODE_L3: w_target = c_DW'(DUTY_L3);
      default: w_target = '0;
    endcase
  end

`ifdef FAN_RAMP_EN
  localparam int              c_RW       = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [c_RW-1:0] c_RAMP_MAX = c_RW'(RAMP_PERIODS - 1);

  fan_state_e      state_q, state_d;
  fan_state_e      w_dir;
  logic [c_RW-1:0] ramp_cnt_q, ramp_cnt_d;
  logic [c_RW-1:0] w_cnt_base;

  // A fresh or reversed direction restarts the period count from zero.
  always_comb begin
    state_d    = state_q;
    ramp_cnt_d = ramp_cnt_q;
    duty_cur_d = duty_cur_q;
    w_dir      = ST_IDLE;
    if (w_target > duty_cur_q) begin
      w_dir = ST_RAMP_UP;
    end else if (w_target < duty_cur_q) begin
      w_dir = ST_RAMP_DOWN;
    end
    w_cnt_base = (w_dir != state_q) ? '0 : ramp_cnt_q;

    if (w_boundary) begin
      if (w_dir == ST_IDLE) begin
        state_d    = ST_IDLE;
        ramp_cnt_d = '0;
      end else if (w_cnt_base == c_RAMP_MAX) begin
        duty_cur_d = (w_dir == ST_RAMP_UP) ? duty_cur_q + 1'b1 : duty_cur_q - 1'b1;
        ramp_cnt_d = '0;
        state_d    = (duty_cur_d == w_target) ? ST_IDLE : w_dir;
      end else begin
        ramp_cnt_d = w_cnt_base + 1'b1;
        state_d    = w_dir;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q    <= ST_IDLE;
      ramp_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ramp_cnt_q <= ramp_cnt_d;
    end
  end
`else
  always_comb begin
    duty_cur_d = duty_cur_q;
    if (w_boundary) begin
      duty_cur_d = w_target;
    end
  end
`endif

  // duty_cur only moves on the boundary edge, so a period never sees two duties.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      duty_cur_q     <= '0;
      pwm_out_q      <= 1'b0;
      period_start_q <= 1'b0;
      busy_q         <= 1'b0;
      mode_err_q     <= 1'b0;
    end else begin
      duty_cur_q     <= duty_cur_d;
      pwm_out_q      <= (w_pwm_cnt < duty_cur_q);
      period_start_q <= w_boundary;
      busy_q         <= (duty_cur_q != w_target);
      mode_err_q     <= ~w_mode_valid;
    end
  end

  assign bus.pwm_out      = pwm_out_q;
  assign bus.duty_cur     = duty_cur_q;
  assign bus.period_start = period_start_q;
  assign bus.busy         = busy_q;
  assign bus.mode_err     = mode_err_q;

endmodule

`default_nettype wire
